// File: rtl/npu_result_drain_if.sv
// Result stream from npu_result_drain toward the host/output buffer.
// Valid/ready handshake carrying one requantized sample, its PE index and a last flag.
interface npu_result_drain_if #(
  parameter int W_OUT = 8,
  parameter int IDX_W = 4
);
  logic             out_valid;
  logic             out_ready;
  logic [W_OUT-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (output out_valid, output out_data, output out_idx, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_idx, input out_last, output out_ready);
endinterface

// File: rtl/npu_result_drain.sv
// Snapshots N PE accumulators on capture and streams them out requantized (shift + saturate).
// Define NPU_DRAIN_DBUF_EN to add a pending bank that absorbs one capture during a drain.
module npu_result_drain #(
  parameter int N     = 10,
  parameter int W_ACC = 20,
  parameter int W_OUT = 8,
  parameter int SHIFT = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture,
  input  logic [N*W_ACC-1:0]   pe_result,
  npu_result_drain_if.master   drain,
  output logic                 busy,
  output logic                 overflow,
  input  logic                 clr_ovf
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam logic [IDX_W-1:0] PTR_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(N - 1);

  localparam logic signed [W_ACC-1:0] SAT_MAX = {{(W_ACC-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_ACC-1:0] SAT_MIN = {{(W_ACC-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};
  localparam logic [W_OUT-1:0]        OUT_MAX = {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic [W_OUT-1:0]        OUT_MIN = {1'b1, {(W_OUT-1){1'b0}}};

  function automatic logic [W_OUT-1:0] requant(input logic [W_ACC-1:0] acc);
    logic signed [W_ACC-1:0] s;
    s = $signed(acc) >>> SHIFT;
    if (s > SAT_MAX) begin
      requant = OUT_MAX;
    end else if (s < SAT_MIN) begin
      requant = OUT_MIN;
    end else begin
      requant = s[W_OUT-1:0];
    end
  endfunction

  logic [0:0]       state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [W_ACC-1:0] bank_r [N];
  logic             ovf_r;
  logic             hs_s;
  logic             final_hs_s;
  logic             load_s;
  logic             pop_s;
  logic             drop_s;
`ifdef NPU_DRAIN_DBUF_EN
  logic [W_ACC-1:0] pend_r [N];
  logic             pend_vld_r;
  logic             pend_load_s;
`endif

  // Decide per cycle whether a capture loads the active bank, is queued, or is dropped.
  always_comb begin
    hs_s       = (state_r == ST_DRAIN) && drain.out_ready;
    final_hs_s = hs_s && (ptr_r == PTR_LAST);
`ifdef NPU_DRAIN_DBUF_EN
    pop_s       = final_hs_s && pend_vld_r;
    load_s      = capture && ((state_r == ST_IDLE) || (final_hs_s && !pend_vld_r));
    pend_load_s = capture && (state_r == ST_DRAIN) && !load_s && (!pend_vld_r || final_hs_s);
    drop_s      = capture && !load_s && !pend_load_s;
`else
    pop_s  = 1'b0;
    load_s = capture && ((state_r == ST_IDLE) || final_hs_s);
    drop_s = capture && !load_s;
`endif
  end

  // State and read pointer; a reload at the final handshake keeps the stream gapless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= PTR_ZERO;
    end else if (load_s || pop_s) begin
      state_r <= ST_DRAIN;
      ptr_r   <= PTR_ZERO;
    end else if (final_hs_s) begin
      state_r <= ST_IDLE;
      ptr_r   <= PTR_ZERO;
    end else if (hs_s) begin
      ptr_r   <= ptr_r + PTR_ONE;
    end else begin
      state_r <= state_r;
      ptr_r   <= ptr_r;
    end
  end

  // Active result bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) bank_r[i] <= {W_ACC{1'b0}};
`ifdef NPU_DRAIN_DBUF_EN
    end else if (pop_s) begin
      for (int i = 0; i < N; i++) bank_r[i] <= pend_r[i];
`endif
    end else if (load_s) begin
      for (int i = 0; i < N; i++) bank_r[i] <= pe_result[i*W_ACC +: W_ACC];
    end else begin
      for (int i = 0; i < N; i++) bank_r[i] <= bank_r[i];
    end
  end

`ifdef NPU_DRAIN_DBUF_EN
  // Pending bank: filled by a capture during a drain, emptied into the active bank at its end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) pend_r[i] <= {W_ACC{1'b0}};
      pend_vld_r <= 1'b0;
    end else if (pend_load_s) begin
      for (int i = 0; i < N; i++) pend_r[i] <= pe_result[i*W_ACC +: W_ACC];
      pend_vld_r <= 1'b1;
    end else if (pop_s) begin
      pend_vld_r <= 1'b0;
    end else begin
      pend_vld_r <= pend_vld_r;
    end
  end
`endif

  // Sticky overflow; a drop in the same cycle as clr_ovf keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (clr_ovf) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Output stream driven straight from state, pointer and the addressed bank entry.
  always_comb begin
    drain.out_valid = (state_r == ST_DRAIN);
    drain.out_idx   = ptr_r;
    drain.out_last  = (state_r == ST_DRAIN) && (ptr_r == PTR_LAST);
    drain.out_data  = requant(bank_r[ptr_r]);
    overflow        = ovf_r;
`ifdef NPU_DRAIN_DBUF_EN
    busy            = (state_r == ST_DRAIN) || pend_vld_r;
`else
    busy            = (state_r == ST_DRAIN);
`endif
  end
endmodule

// File: tb/tb_npu_result_drain.sv
// Directed + random stimulus for npu_result_drain, checked against a queue-based model of the
// output stream (each accepted capture appends N requantized samples).
module tb_npu_result_drain;
  localparam int N     = 10;
  localparam int W_ACC = 20;
  localparam int W_OUT = 8;
  localparam int SHIFT = 4;
  localparam int IDX_W = $clog2(N);
`ifdef NPU_DRAIN_DBUF_EN
  localparam int CAP_LIMIT = N;
`else
  localparam int CAP_LIMIT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               capture;
  logic [N*W_ACC-1:0] pe_result;
  logic               busy;
  logic               overflow;
  logic               clr_ovf;

  npu_result_drain_if #(.W_OUT(W_OUT), .IDX_W(IDX_W)) drain_bus ();

  npu_result_drain #(.N(N), .W_ACC(W_ACC), .W_OUT(W_OUT), .SHIFT(SHIFT), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .capture(capture), .pe_result(pe_result),
    .drain(drain_bus), .busy(busy), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  typedef struct { int data; int idx; } item_t;
  item_t exp_q[$];
  int    vals[N];
  bit    exp_ovf;
  int    checks;
  int    errors;

  function automatic int requant(int v);
    int s;
    s = v >>> SHIFT;
    if (s > 127) return 127;
    if (s < -128) return -128;
    return s;
  endfunction

  function automatic int sx(int raw);
    logic signed [W_ACC-1:0] t;
    t = raw[W_ACC-1:0];
    return int'(t);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic rand_vals();
    for (int i = 0; i < N; i++)
      vals[i] = ($urandom_range(0, 1) == 0) ? sx($urandom) : ($urandom_range(0, 4095) - 2048);
  endtask

  // One clock: check outputs at the falling edge, advance the model, drive the next inputs.
  task automatic cyc(input bit cap, input bit rdy, input bit clr);
    int  left;
    int  hs;
    bit  ev;
    int  ed;
    int  ei;
    @(negedge clk);
    left = exp_q.size();
    ev = (left > 0);
    ed = ev ? exp_q[0].data : 0;
    ei = ev ? exp_q[0].idx : 0;
    check("valid", drain_bus.out_valid, ev);
    check("busy", busy, ev);
    check("overflow", overflow, exp_ovf);
    check("idx", drain_bus.out_idx, ei);
    check("last", drain_bus.out_last, ev && (ei == N - 1));
    if (ev) check("data", $signed(drain_bus.out_data), ed);
    hs = (ev && rdy) ? 1 : 0;
    if (hs == 1) void'(exp_q.pop_front());
    if (cap && (left - hs <= CAP_LIMIT)) begin
      for (int i = 0; i < N; i++) exp_q.push_back('{requant(vals[i]), i});
    end else if (cap) begin
      exp_ovf = 1'b1;
    end else if (clr) begin
      exp_ovf = 1'b0;
    end
    if (cap && clr && !(left - hs <= CAP_LIMIT)) exp_ovf = 1'b1;
    else if (cap && clr) exp_ovf = 1'b0;
    capture             = cap;
    drain_bus.out_ready = rdy;
    clr_ovf             = clr;
    for (int i = 0; i < N; i++) pe_result[i*W_ACC +: W_ACC] = vals[i][W_ACC-1:0];
  endtask

  // Advance with ready=1 until the model shows the given index at the head of the stream.
  task automatic run_to_idx(input int idx);
    for (int k = 0; k < 4 * N && !(exp_q.size() > 0 && exp_q[0].idx == idx); k++) cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic drain_all(input int pat);
    bit rdy;
    for (int k = 0; k < 400 && exp_q.size() > 0; k++) begin
      case (pat)
        0:       rdy = 1'b1;
        1:       rdy = (k % 4 == 0) || (k % 4 == 3);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      cyc(1'b0, rdy, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0; exp_ovf = 1'b0;
    rst_n = 1'b0; capture = 1'b0; clr_ovf = 1'b0; pe_result = '0;
    drain_bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) vals[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state: idle, bank cleared.
    cyc(1'b0, 1'b0, 1'b0);
    check("data_reset", $signed(drain_bus.out_data), 0);

    // Basic drain: 16*i -> 0..9.
    for (int i = 0; i < N; i++) vals[i] = 16 * i;
    cyc(1'b1, 1'b1, 1'b0);
    drain_all(0);

    // Saturation corners plus random fill.
    rand_vals();
    vals[0] = sx(32'h7FFFF); vals[1] = sx(32'h80000);
    vals[2] = sx(32'h007F0); vals[3] = sx(32'hFF800);
    cyc(1'b1, 1'b1, 1'b0);
    drain_all(0);

    // Backpressure with ready pattern 1,0,0,1.
    rand_vals();
    cyc(1'b1, 1'b0, 1'b0);
    drain_all(1);

    // Back-to-back: second capture in the idx 9 cycle.
    for (int i = 0; i < N; i++) vals[i] = 16 * i;
    cyc(1'b1, 1'b1, 1'b0);
    run_to_idx(N - 1);
    for (int i = 0; i < N; i++) vals[i] = 16 * (100 + i);
    cyc(1'b1, 1'b1, 1'b0);
    drain_all(0);

    // Capture at idx 3 (dropped or queued) and another at idx 5, then clear.
    rand_vals();
    cyc(1'b1, 1'b1, 1'b0);
    run_to_idx(3);
    rand_vals();
    cyc(1'b1, 1'b1, 1'b0);
    run_to_idx(5);
    rand_vals();
    cyc(1'b1, 1'b1, 1'b0);
    drain_all(0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    // Drop coinciding with clr_ovf: set wins.
    rand_vals();
    cyc(1'b1, 1'b1, 1'b0);
    run_to_idx(2);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    drain_all(0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      rand_vals();
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    drain_all(2);

    // Asynchronous reset mid-drain.
    rand_vals();
    cyc(1'b1, 1'b1, 1'b0);
    run_to_idx(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("valid_async_rst", drain_bus.out_valid, 0);
    check("busy_async_rst", busy, 0);
    check("ovf_async_rst", overflow, 0);
    exp_q.delete();
    exp_ovf = 1'b0;
    capture = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    check("data_after_rst", $signed(drain_bus.out_data), 0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    rand_vals();
    cyc(1'b1, 1'b1, 1'b0);
    drain_all(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/npu_result_drain.md
Name: npu_result_drain

Overview:
- Read-side counterpart of the NPU scheduler's buffer-load path. The scheduler writes operands into PE buffers; this block takes the N PE accumulator results and returns them.
- On a capture pulse, it snapshots all N PE accumulators into a local bank.
- It requantizes each result: arithmetic shift, then saturation to signed W_OUT.
- It streams the results out one per handshake over a valid/ready interface toward the host/output buffer. This realises the WRITE_BACK phase of a compute pass.

Parameters:
- N, 10, number of PEs / results per capture
- W_ACC, 20, signed PE accumulator width
- W_OUT, 8, signed output sample width
- SHIFT, 4, arithmetic right-shift applied before saturation (0..W_ACC-1)
- IDX_W, $clog2(N), width of result index

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- capture  in  1  single-cycle pulse: pe_result holds a complete set of results
- pe_result  in  N*W_ACC  PE accumulators, PE i at bits [i*W_ACC +: W_ACC], signed
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  W_OUT  requantized result, signed
- out_idx  out  IDX_W  PE index of out_data
- out_last  out  1  high with the last element (idx N-1)
- busy  out  1  drain in progress or result pending
- overflow  out  1  sticky: a capture was dropped
- clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: state=IDLE, ptr=0, bank=0, out_valid=0, out_idx=0, out_last=0, busy=0, overflow=0. out_data=0 because bank=0.
- FSM states:
  - IDLE: out_valid=0. On capture, latch all N entries of pe_result into the bank, set ptr=0, go to DRAIN.
  - DRAIN: out_valid=1, out_idx=ptr, out_last=(ptr==N-1).
- DRAIN handshake (out_valid && out_ready):
  - If ptr<N-1: ptr++.
  - If ptr==N-1: go to IDLE and set ptr=0.
  - Without a handshake, ptr and out_data hold stable; AXI-style, valid is never withdrawn.
- Latency: capture in cycle t gives out_valid=1 and idx 0 in cycle t+1. With out_ready held high, N elements come out in N consecutive cycles.
- busy=1 whenever state==DRAIN, or a pending bank is valid (optional feature).
- Requantization (combinational from the bank entry at ptr):
  - s = bank[ptr] >>> SHIFT, sign-preserving.
  - If s > 2^(W_OUT-1)-1, out_data = 2^(W_OUT-1)-1.
  - If s < -2^(W_OUT-1), out_data = -2^(W_OUT-1).
  - Otherwise out_data = s[W_OUT-1:0].
- Capture during DRAIN:
  - In the same cycle as the final handshake (ptr==N-1 accepted): the capture is accepted. Latch the new bank, ptr=0, remain in DRAIN; the stream has no bubble.
  - Any other DRAIN cycle: the capture is dropped, overflow is set, and the bank is unchanged.
- overflow:
  - Sticky.
  - Cleared by clr_ovf.
  - If clr_ovf coincides with a new drop, set wins.
- Asynchronous reset mid-drain aborts the stream immediately: out_valid=0 and all data is discarded.

Optional Feature:
- Macro: NPU_DRAIN_DBUF_EN.
- When defined:
  - A second (pending) bank with a valid flag is added.
  - A capture during DRAIN, when pending is empty, is stored in pending instead of being dropped.
  - At the final handshake, if pending is valid, it moves to the active bank, ptr=0, the state stays DRAIN, and pending is cleared.
  - A capture in that same cycle is written to pending.
  - overflow is set only when pending is already full and neither bank frees up that cycle.
- When undefined:
  - Single bank only.
  - Drop rules exactly as described in Behaviour.

Test Plan:
- Basic drain: pe_result[i]=16*i (i=0..9), SHIFT=4, capture, out_ready=1 → next 10 cycles out_data=0..9, out_idx=0..9, out_last only at idx 9, then out_valid=0 and busy=0.
- Saturation: entries 0x7FFFF, 0x80000, 0x007F0, 0xFF800 → out_data +127, -128, +127, -128.
- Backpressure: toggle out_ready 1,0,0,1,… → out_data/out_idx stable while ready=0, 10 accepts total, no skipped or duplicated idx.
- Back-to-back: second capture (values 100+i) asserted in the cycle idx 9 is accepted → the next cycle shows idx 0 from the new set; no idle cycle; overflow=0.
- Drop/overflow (macro off): capture at idx 3 → the stream continues with the original data, overflow=1 afterwards; clr_ovf pulse → overflow=0. With macro on: the same capture is queued and drained after idx 9, overflow=0; a third capture while pending is full → overflow=1.
- Reset mid-drain: assert rst_n=0 at idx 5 → out_valid=0, busy=0 asynchronously; after release, no output until the next capture.
